// File: rtl/vgachargen_apb_bridge.sv
// rtl/vgachargen_apb_bridge.sv - APB3 completer mapping register accesses onto the VGA char generator memories
module vgachargen_apb_bridge #(
    parameter int ADDR_W    = 16,
    parameter int MAP_DEPTH = 2400,
    parameter int GLYPHS    = 128
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [ADDR_W-1:0]            paddr_i,
    input  logic [31:0]                  pwdata_i,
    output logic [31:0]                  prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic [$clog2(MAP_DEPTH)-1:0] ch_map_addr_o,
    output logic [$clog2(MAP_DEPTH)-1:0] col_map_addr_o,
    output logic [7:0]                   ch_map_data_o,
    output logic [7:0]                   col_map_data_o,
    input  logic [7:0]                   ch_map_data_i,
    input  logic [7:0]                   col_map_data_i,
    output logic                         ch_map_wen_o,
    output logic                         col_map_wen_o,
    output logic [$clog2(GLYPHS)-1:0]    ch_t_rw_addr_o,
    output logic [127:0]                 ch_t_rw_data_o,
    input  logic [127:0]                 ch_t_rw_data_i,
    output logic                         ch_t_rw_wen_o
);
    localparam int MAP_AW = $clog2(MAP_DEPTH);
    localparam int GLY_AW = $clog2(GLYPHS);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, RESP} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [11:0]         map_idx;
    logic [6:0]          gly_idx;
    logic [1:0]          word_sel;
    logic                aligned;
    logic                is_ch;
    logic                is_col;
    logic                is_gly;
    logic                dec_err;
    logic                access;
    logic                rd_load;
    logic [31:0]         rd_word;
    logic [127:0]        merged;
    logic [MAP_AW-1:0]   map_addr_q;
    logic [GLY_AW-1:0]   gly_addr_q;

    // Address decode: char map 0x0000, colour map 0x4000, glyph table 0x8000 (16 bytes per glyph)
    always_comb begin
        map_idx  = paddr_i[13:2];
        gly_idx  = paddr_i[10:4];
        word_sel = paddr_i[3:2];
        aligned  = (paddr_i[1:0] == 2'b00);
        is_ch    = aligned && (paddr_i[15:14] == 2'b00) && (int'(map_idx) < MAP_DEPTH);
        is_col   = aligned && (paddr_i[15:14] == 2'b01) && (int'(map_idx) < MAP_DEPTH);
        is_gly   = aligned && (paddr_i[15:11] == 5'b10000) && (int'(gly_idx) < GLYPHS);
        dec_err  = !(is_ch || is_col || is_gly);
        access   = psel_i && penable_i;
    end

    // Read-data selection and glyph merge; memory data is valid in the cycle after the address
    always_comb begin
        rd_word = ch_t_rw_data_i[{word_sel, 5'b00000} +: 32];
        if (is_ch) begin
            rd_word = {24'h000000, ch_map_data_i};
        end else if (is_col) begin
            rd_word = {24'h000000, col_map_data_i};
        end
        merged = ch_t_rw_data_i;
        merged[{word_sel, 5'b00000} +: 32] = pwdata_i;
    end

    // Memory addresses follow paddr while selected and hold the last selected value otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_addr_q <= '0;
            gly_addr_q <= '0;
        end else if (psel_i) begin
            map_addr_q <= map_idx[MAP_AW-1:0];
            gly_addr_q <= gly_idx[GLY_AW-1:0];
        end
    end

    // Address outputs, forced to zero while reset is asserted
    always_comb begin
        ch_map_addr_o  = map_addr_q;
        ch_t_rw_addr_o = gly_addr_q;
        if (!rst_ni) begin
            ch_map_addr_o  = '0;
            ch_t_rw_addr_o = '0;
        end else if (psel_i) begin
            ch_map_addr_o  = map_idx[MAP_AW-1:0];
            ch_t_rw_addr_o = gly_idx[GLY_AW-1:0];
        end
        col_map_addr_o = ch_map_addr_o;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read data is captured at the end of RD_WAIT and held until the next read completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prdata_o <= 32'h0;
        end else if (rd_load) begin
            prdata_o <= rd_word;
        end
    end

    // Next state and response/strobe outputs; reset kills strobes asynchronously
    always_comb begin
        state_d       = state_q;
        pready_o      = 1'b0;
        pslverr_o     = 1'b0;
        ch_map_wen_o  = 1'b0;
        col_map_wen_o = 1'b0;
        ch_t_rw_wen_o = 1'b0;
        rd_load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (dec_err) begin
                        pready_o  = 1'b1;
                        pslverr_o = 1'b1;
                    end else if (!pwrite_i) begin
                        state_d = RD_WAIT;
                    end else if (is_gly) begin
                        state_d = RMW_WAIT;
                    end else begin
                        pready_o      = 1'b1;
                        ch_map_wen_o  = is_ch;
                        col_map_wen_o = is_col;
                    end
                end
            end
            RD_WAIT: begin
                if (access) begin
                    rd_load = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WAIT: begin
                if (access) begin
                    ch_t_rw_wen_o = 1'b1;
                    pready_o      = 1'b1;
                end
                state_d = IDLE;
            end
            RESP: begin
                pready_o = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst_ni) begin
            pready_o      = 1'b0;
            pslverr_o     = 1'b0;
            ch_map_wen_o  = 1'b0;
            col_map_wen_o = 1'b0;
            ch_t_rw_wen_o = 1'b0;
            rd_load       = 1'b0;
        end
        ch_map_data_o  = ch_map_wen_o  ? pwdata_i[7:0] : 8'h00;
        col_map_data_o = col_map_wen_o ? pwdata_i[7:0] : 8'h00;
        ch_t_rw_data_o = ch_t_rw_wen_o ? merged : 128'h0;
    end
endmodule

// File: tb/tb_vgachargen_apb_bridge.sv
// tb/tb_vgachargen_apb_bridge.sv - self-checking bench for vgachargen_apb_bridge
module tb_vgachargen_apb_bridge;
    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         psel    = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite  = 1'b0;
    logic [15:0]  paddr   = 16'h0;
    logic [31:0]  pwdata  = 32'h0;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [11:0]  ch_addr;
    logic [11:0]  col_addr;
    logic [7:0]   ch_wdata;
    logic [7:0]   col_wdata;
    logic [7:0]   ch_rdata  = 8'h0;
    logic [7:0]   col_rdata = 8'h0;
    logic         ch_wen;
    logic         col_wen;
    logic [6:0]   gly_addr;
    logic [127:0] gly_wdata;
    logic [127:0] gly_rdata = 128'h0;
    logic         gly_wen;

    always #5 clk = ~clk;

    vgachargen_apb_bridge dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .psel_i         (psel),
        .penable_i      (penable),
        .pwrite_i       (pwrite),
        .paddr_i        (paddr),
        .pwdata_i       (pwdata),
        .prdata_o       (prdata),
        .pready_o       (pready),
        .pslverr_o      (pslverr),
        .ch_map_addr_o  (ch_addr),
        .col_map_addr_o (col_addr),
        .ch_map_data_o  (ch_wdata),
        .col_map_data_o (col_wdata),
        .ch_map_data_i  (ch_rdata),
        .col_map_data_i (col_rdata),
        .ch_map_wen_o   (ch_wen),
        .col_map_wen_o  (col_wen),
        .ch_t_rw_addr_o (gly_addr),
        .ch_t_rw_data_o (gly_wdata),
        .ch_t_rw_data_i (gly_rdata),
        .ch_t_rw_wen_o  (gly_wen)
    );

    function automatic logic [7:0] init_ch(input int i);
        return 8'((i * 7 + 3) % 256);
    endfunction

    function automatic logic [7:0] init_col(input int i);
        return 8'((i * 13 + 90) % 256);
    endfunction

    function automatic logic [127:0] init_gly(input int g);
        logic [31:0] t;
        t = 32'(g) * 32'h9E3779B1;
        if (g == 5) return 128'h0123456789ABCDEF0123456789ABCDEF;
        return {t, ~t, t ^ 32'h5A5A5A5A, t + 32'd1};
    endfunction

    // Memory environment: synchronous read, write on strobe, self-preload on first edge
    logic [7:0]   ch_mem  [0:2399];
    logic [7:0]   col_mem [0:2399];
    logic [127:0] gly_mem [0:127];
    logic         mem_ready   = 1'b0;
    int           ch_wen_cnt  = 0;
    int           col_wen_cnt = 0;
    int           gly_wen_cnt = 0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 2400; i++) begin
                ch_mem[i]  <= init_ch(i);
                col_mem[i] <= init_col(i);
            end
            for (int g = 0; g < 128; g++) gly_mem[g] <= init_gly(g);
            mem_ready <= 1'b1;
        end else begin
            if (ch_wen)  begin ch_mem[ch_addr]   <= ch_wdata;  ch_wen_cnt  <= ch_wen_cnt + 1;  end
            if (col_wen) begin col_mem[col_addr] <= col_wdata; col_wen_cnt <= col_wen_cnt + 1; end
            if (gly_wen) begin gly_mem[gly_addr] <= gly_wdata; gly_wen_cnt <= gly_wen_cnt + 1; end
        end
        ch_rdata  <= (ch_addr < 12'd2400)  ? ch_mem[ch_addr]   : 8'h00;
        col_rdata <= (col_addr < 12'd2400) ? col_mem[col_addr] : 8'h00;
        gly_rdata <= gly_mem[gly_addr];
    end

    // Reference model of memory contents, updated from the bench's own view of each transfer
    logic [7:0]   ref_ch  [0:2399];
    logic [7:0]   ref_col [0:2399];
    logic [127:0] ref_gly [0:127];
    int           exp_ch_cnt  = 0;
    int           exp_col_cnt = 0;
    int           exp_gly_cnt = 0;
    logic [31:0]  last_rdata  = 32'h0;

    int           errors = 0;
    int           checks = 0;

    // Per-transfer observations
    logic         t_done;
    logic         t_err;
    logic [31:0]  t_rdata;
    int           t_cycles;
    int           t_ch_w;
    int           t_col_w;
    int           t_gly_w;
    int           t_wen_nr;
    logic [11:0]  t_map_addr;
    logic [7:0]   t_map_data;
    logic [6:0]   t_gly_addr;
    logic [127:0] t_gly_data;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pready"}, pready, 0);
        check({tag, " pslverr"}, pslverr, 0);
        check({tag, " prdata"}, prdata, 0);
        check({tag, " wen"}, {ch_wen, col_wen, gly_wen}, 0);
        check({tag, " data_o"}, {ch_wdata, col_wdata, gly_wdata}, 0);
        check({tag, " addr_o"}, {ch_addr, col_addr, gly_addr}, 0);
    endtask

    // One APB transfer; called just after a rising edge, returns just after the completing edge
    task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        t_done = 1'b0; t_err = 1'b0; t_rdata = 32'h0; t_cycles = 0;
        t_ch_w = 0; t_col_w = 0; t_gly_w = 0; t_wen_nr = 0;
        while (!t_done && t_cycles < 10) begin
            @(negedge clk);
            t_cycles++;
            if (ch_wen)  begin t_ch_w++;  t_map_addr = ch_addr;  t_map_data = ch_wdata;  end
            if (col_wen) begin t_col_w++; t_map_addr = col_addr; t_map_data = col_wdata; end
            if (gly_wen) begin t_gly_w++; t_gly_addr = gly_addr; t_gly_data = gly_wdata; end
            if ((ch_wen || col_wen || gly_wen) && !pready) t_wen_nr++;
            if (pready) begin
                t_done  = 1'b1;
                t_err   = pslverr;
                t_rdata = prdata;
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    // Transfer with expectations derived from the address map by plain arithmetic
    task automatic xfer(input string tag, input logic wr, input logic [15:0] addr, input logic [31:0] wd);
        int           a, kind, idx, g, w, exp_cyc;
        logic [127:0] mask, exp_gly, sh;
        logic [31:0]  exp_rd;
        a = int'(addr);
        kind = 3; idx = 0; g = 0; w = 0;
        if (a % 4 == 0) begin
            if (a < 'h4000) begin
                idx = a / 4;
                if (idx < 2400) kind = 0;
            end else if (a < 'h8000) begin
                idx = (a - 'h4000) / 4;
                if (idx < 2400) kind = 1;
            end else if (a < 'h8800) begin
                g = (a - 'h8000) / 16;
                w = (a % 16) / 4;
                kind = 2;
            end
        end
        exp_cyc = (kind == 3) ? 1 : (!wr ? 3 : (kind == 2 ? 2 : 1));
        apb(wr, addr, wd);
        check({tag, " done"}, t_done, 1);
        check({tag, " slverr"}, t_err, (kind == 3));
        check({tag, " latency"}, t_cycles, exp_cyc);
        check({tag, " ch_wen count"}, t_ch_w, (wr && kind == 0));
        check({tag, " col_wen count"}, t_col_w, (wr && kind == 1));
        check({tag, " gly_wen count"}, t_gly_w, (wr && kind == 2));
        check({tag, " wen without pready"}, t_wen_nr, 0);
        if (kind == 3 || wr) begin
            check({tag, " prdata held"}, t_rdata, last_rdata);
        end else begin
            if (kind == 0) exp_rd = {24'h0, ref_ch[idx]};
            else if (kind == 1) exp_rd = {24'h0, ref_col[idx]};
            else begin
                sh = ref_gly[g] >> (32 * w);
                exp_rd = sh[31:0];
            end
            check({tag, " prdata"}, t_rdata, exp_rd);
            last_rdata = exp_rd;
        end
        if (wr && kind == 0) begin
            check({tag, " ch addr"}, t_map_addr, idx);
            check({tag, " ch data"}, t_map_data, wd[7:0]);
            ref_ch[idx] = wd[7:0];
            exp_ch_cnt++;
        end else if (wr && kind == 1) begin
            check({tag, " col addr"}, t_map_addr, idx);
            check({tag, " col data"}, t_map_data, wd[7:0]);
            ref_col[idx] = wd[7:0];
            exp_col_cnt++;
        end else if (wr && kind == 2) begin
            mask    = 128'hFFFFFFFF << (32 * w);
            exp_gly = (ref_gly[g] & ~mask) | ({96'h0, wd} << (32 * w));
            check({tag, " gly addr"}, t_gly_addr, g);
            check({tag, " gly data"}, t_gly_data, exp_gly);
            ref_gly[g] = exp_gly;
            exp_gly_cnt++;
        end
    endtask

    logic [15:0] r_addr;
    logic [31:0] r_data;
    logic        r_wr;
    int          r_sel;
    int          r_idx;

    initial begin
        for (int i = 0; i < 2400; i++) begin
            ref_ch[i]  = init_ch(i);
            ref_col[i] = init_col(i);
        end
        for (int g = 0; g < 128; g++) ref_gly[g] = init_gly(g);

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Character map write then read
        xfer("ch_wr0", 1'b1, 16'h0000, 32'hFFFF_FF41);
        check("ch_wr0 data 0x41", t_map_data, 8'h41);
        xfer("ch_rd0", 1'b0, 16'h0000, 32'h0);
        check("ch_rd0 value 0x41", t_rdata, 32'h0000_0041);

        // Colour map last entry and first out-of-range entry
        xfer("col_last", 1'b1, 16'h4000 + 16'(4 * 2399), 32'h0000_001F);
        check("col_last addr 2399", t_map_addr, 12'd2399);
        xfer("col_2400_wr", 1'b1, 16'h4000 + 16'(4 * 2400), 32'h0000_0077);
        xfer("ch_2400_rd", 1'b0, 16'(4 * 2400), 32'h0);
        xfer("col_last_rd", 1'b0, 16'h4000 + 16'(4 * 2399), 32'h0);

        // Glyph read-modify-write of glyph 5 word 2
        xfer("gly5_wr", 1'b1, 16'h8000 + 16'(16 * 5 + 8), 32'hDEAD_BEEF);
        check("gly5 merged", t_gly_data, 128'h01234567_DEADBEEF_01234567_89ABCDEF);
        xfer("gly5_rd_w2", 1'b0, 16'h8000 + 16'(16 * 5 + 8), 32'h0);
        xfer("gly5_rd_w3", 1'b0, 16'h8000 + 16'(16 * 5 + 12), 32'h0);
        @(negedge clk);
        check("gly addr hold", gly_addr, 7'd5);

        // Misaligned and unmapped accesses
        xfer("misaligned", 1'b0, 16'h0002, 32'h0);
        xfer("unmapped", 1'b0, 16'h9000, 32'h0);
        xfer("unmapped_wr", 1'b1, 16'h9000, 32'h1234_5678);

        // Reset while waiting in the read-modify-write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 16'h8000 + 16'(16 * 9 + 4); pwdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("rmw first cycle pready", pready, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_rmw");
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rdata = 32'h0;
        check("rst_rmw gly writes", gly_wen_cnt, exp_gly_cnt);
        xfer("gly9_rd_w1", 1'b0, 16'h8000 + 16'(16 * 9 + 4), 32'h0);

        // Random back-to-back traffic across all regions
        for (int n = 0; n < 80; n++) begin
            r_sel  = int'($urandom_range(0, 9));
            r_wr   = 1'($urandom_range(0, 1));
            r_data = $urandom;
            r_idx  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2399));
            if (r_sel == 0) begin
                case ($urandom_range(0, 3))
                    0: r_addr = 16'($urandom_range(0, 16'hFFFF)) | 16'(1 + $urandom_range(0, 2));
                    1: r_addr = 16'(4 * $urandom_range(2400, 4095)) + (($urandom_range(0, 1) == 1) ? 16'h4000 : 16'h0000);
                    2: r_addr = 16'h8800 + 16'(4 * $urandom_range(0, 511));
                    default: r_addr = 16'hC000 + 16'(4 * $urandom_range(0, 4095));
                endcase
            end else if (r_sel < 4) begin
                r_addr = 16'(4 * r_idx);
            end else if (r_sel < 7) begin
                r_addr = 16'h4000 + 16'(4 * r_idx);
            end else begin
                r_addr = 16'h8000 + 16'(16 * $urandom_range(0, 15) + 4 * $urandom_range(0, 3));
            end
            xfer("rnd", r_wr, r_addr, r_data);
        end

        check("total ch_wen", ch_wen_cnt, exp_ch_cnt);
        check("total col_wen", col_wen_cnt, exp_col_cnt);
        check("total gly_wen", gly_wen_cnt, exp_gly_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
